// File: rtl/isa_pkg.sv
// ISA definitions shared by the decode-stage control logic: opcodes,
// instruction field positions, operand-class decoders and flush FSM states.
package isa_pkg;

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpAdd  = 4'b0100;
  localparam logic [3:0] OpInc  = 4'b0101;
  localparam logic [3:0] OpNeg  = 4'b0110;
  localparam logic [3:0] OpSub  = 4'b0111;
  localparam logic [3:0] OpJ    = 4'b1000;
  localparam logic [3:0] OpBrz  = 4'b1001;
  localparam logic [3:0] OpJm   = 4'b1010;
  localparam logic [3:0] OpBrn  = 4'b1011;
  localparam logic [3:0] OpLd   = 4'b1110;
  localparam logic [3:0] OpSvpc = 4'b1111;

  // Instruction field bit positions.
  localparam int unsigned OpHi = 31;
  localparam int unsigned OpLo = 28;
  localparam int unsigned RdHi = 27;
  localparam int unsigned RdLo = 22;
  localparam int unsigned RsHi = 21;
  localparam int unsigned RsLo = 16;
  localparam int unsigned RtHi = 15;
  localparam int unsigned RtLo = 10;

  typedef enum logic {StRun, StFlush} flush_state_e;

  // Opcode writes the rd register.
  function automatic logic wr_rd(input logic [3:0] op);
    logic r;
    case (op)
      OpSvpc, OpLd, OpAdd, OpInc, OpNeg, OpSub: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcode reads the rs register.
  function automatic logic rd_rs(input logic [3:0] op);
    logic r;
    case (op)
      OpLd, OpSt, OpAdd, OpInc, OpNeg, OpSub,
      OpJ, OpBrz, OpJm, OpBrn:                  r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcode reads the rt register.
  function automatic logic rd_rt(input logic [3:0] op);
    logic r;
    case (op)
      OpSt, OpAdd, OpSub: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flush_fsm.sv
// Flush sequencer: after a redirect, squashes IF/ID for FLUSH_CYCLES cycles.
// A redirect while flushing restarts the window.
module flush_fsm
  import isa_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_redirect,
  output logic flush,
  output logic in_flush
);

  localparam logic [2:0] Reload = 3'(FLUSH_CYCLES);

  flush_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         flush_q, flush_d;

  // Next state: load on redirect, count down the flush window, then return to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (ex_redirect) begin
          state_d = StFlush;
          cnt_d   = Reload;
        end
      end
      StFlush: begin
        if (ex_redirect) begin
          cnt_d = Reload;
        end else if (cnt_q <= 3'd1) begin
          state_d = StRun;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
    endcase
    flush_d = (state_d == StFlush);
  end

  // State, counter and registered flush output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign flush    = flush_q;
  assign in_flush = (state_q == StFlush);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard control: register scoreboard, RAW/WAW stall, redirect
// flush sequencing and a saturating stall counter.
module hazard_ctrl
  import isa_pkg::*;
#(
  parameter int unsigned NREG         = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      inst,
  input  logic             wb_rw,
  input  logic [5:0]       wb_rd,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             issue,
  output logic             flush,
  output logic [NREG-1:0]  busy_vec,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [3:0] op;
  logic [5:0] rd, rs, rt;
  logic       cls_wr, cls_rs, cls_rt;
  logic       hazard;
  logic       in_flush;
  logic       unused_inst;

  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op     = inst[OpHi:OpLo];
  assign rd     = inst[RdHi:RdLo];
  assign rs     = inst[RsHi:RsLo];
  assign rt     = inst[RtHi:RtLo];
  assign cls_wr = wr_rd(op);
  assign cls_rs = rd_rs(op);
  assign cls_rt = rd_rt(op);

  assign unused_inst = ^inst[RtLo-1:0];

  flush_fsm #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_fsm (
    .clk        (clk),
    .rst        (rst),
    .ex_redirect(ex_redirect),
    .flush      (flush),
    .in_flush   (in_flush)
  );

  // Hazard check against registered scoreboard only; no writeback bypass.
  always_comb begin
    hazard = id_valid & ((cls_rs & busy_q[rs]) | (cls_rt & busy_q[rt]) | (cls_wr & busy_q[rd]));
    stall  = 1'b0;
    issue  = 1'b0;
    if (!in_flush) begin
      stall = hazard & ~ex_redirect;
      issue = id_valid & ~hazard & ~ex_redirect;
    end
  end

  // Scoreboard next state: writeback clear first so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_rw) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue && cls_wr) begin
      busy_d[rd] = 1'b1;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Scoreboard and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec  = busy_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run checked against a behavioural model of the scoreboard and flush window.
module tb_hazard_ctrl;

  localparam int NR   = 64;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst, id_valid, wb_rw, ex_redirect;
  logic [31:0]   inst;
  logic [5:0]    wb_rd;
  logic          stall, issue, flush;
  logic [NR-1:0] busy_vec;
  logic [CW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  bit   mbusy [NR];
  int   mflush = 0;
  int   mcnt = 0;
  logic exp_stall, exp_issue;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .NREG        (NR),
    .FLUSH_CYCLES(FC),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .inst       (inst),
    .wb_rw      (wb_rw),
    .wb_rd      (wb_rd),
    .ex_redirect(ex_redirect),
    .stall      (stall),
    .issue      (issue),
    .flush      (flush),
    .busy_vec   (busy_vec),
    .stall_cnt  (stall_cnt)
  );

  function automatic bit m_wr(logic [3:0] op);
    return op inside {4'b1111, 4'b1110, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
  endfunction

  function automatic bit m_rs(logic [3:0] op);
    return op inside {4'b1110, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                      4'b1000, 4'b1001, 4'b1010, 4'b1011};
  endfunction

  function automatic bit m_rt(logic [3:0] op);
    return op inside {4'b0011, 4'b0100, 4'b0111};
  endfunction

  function automatic logic [31:0] mk(logic [3:0] op, logic [5:0] d, logic [5:0] s,
                                     logic [5:0] t);
    return {op, d, s, t, 10'd0};
  endfunction

  function automatic logic [NR-1:0] mvec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = mbusy[i];
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge and compute expected comb outputs.
  task automatic cyc(input logic r, input logic v, input logic [31:0] ins, input logic wrw,
                     input logic [5:0] wrd, input logic redir);
    bit hz;
    @(negedge clk);
    rst = r; id_valid = v; inst = ins; wb_rw = wrw; wb_rd = wrd; ex_redirect = redir;
    #1;
    hz = v && ((m_rs(ins[31:28]) && mbusy[ins[21:16]]) ||
               (m_rt(ins[31:28]) && mbusy[ins[15:10]]) ||
               (m_wr(ins[31:28]) && mbusy[ins[27:22]]));
    if (mflush > 0) begin
      exp_stall = 1'b0;
      exp_issue = 1'b0;
    end else begin
      exp_stall = hz && !redir;
      exp_issue = v && !hz && !redir;
    end
  endtask

  // Advance the model across the rising edge.
  task automatic adv();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) mbusy[i] = 1'b0;
      mflush = 0;
      mcnt   = 0;
    end else begin
      if (wb_rw) mbusy[wb_rd] = 1'b0;
      if (exp_issue && m_wr(inst[31:28])) mbusy[inst[27:22]] = 1'b1;
      if (exp_stall && mcnt < CMAX) mcnt++;
      if (ex_redirect) mflush = FC;
      else if (mflush > 0) mflush--;
    end
  endtask

  task automatic do_reset();
    cyc(1, 0, 32'h0, 0, 6'd0, 0);
    adv();
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0, 0, 32'h0, 0, 6'd0, 0);
    tests++; if (busy_vec !== '0) begin fails++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush: got %b want 0", flush); end
    tests++; if (stall_cnt !== '0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    tests++; if ({stall, issue} !== 2'b00) begin fails++; $display("FAIL reset_idle: got stall/issue %b want 00", {stall, issue}); end
    adv();
  endtask

  task automatic test_raw();
    do_reset();
    cyc(0, 1, mk(4'b0100, 6'd5, 6'd1, 6'd2), 0, 6'd0, 0);
    tests++; if (issue !== 1'b1) begin fails++; $display("FAIL raw_first_issue: got %b want 1", issue); end
    adv();
    cyc(0, 1, mk(4'b0111, 6'd6, 6'd5, 6'd3), 0, 6'd0, 0);
    tests++; if ({stall, issue} !== 2'b10) begin fails++; $display("FAIL raw_stall: got stall/issue %b want 10", {stall, issue}); end
    tests++; if (busy_vec[5] !== 1'b1) begin fails++; $display("FAIL raw_busy5: got %b want 1", busy_vec[5]); end
    adv();
    cyc(0, 1, mk(4'b0111, 6'd6, 6'd5, 6'd3), 1, 6'd5, 0);
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL raw_no_bypass: got %b want 1", stall); end
    tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL raw_cnt1: got %0d want 1", stall_cnt); end
    adv();
    cyc(0, 1, mk(4'b0111, 6'd6, 6'd5, 6'd3), 0, 6'd0, 0);
    tests++; if (busy_vec[5] !== 1'b0) begin fails++; $display("FAIL raw_clear5: got %b want 0", busy_vec[5]); end
    tests++; if ({stall, issue} !== 2'b01) begin fails++; $display("FAIL raw_release: got stall/issue %b want 01", {stall, issue}); end
    tests++; if (stall_cnt !== 4'd2) begin fails++; $display("FAIL raw_cnt2: got %0d want 2", stall_cnt); end
    adv();
    cyc(0, 0, 32'h0, 0, 6'd0, 0);
    tests++; if (busy_vec[6] !== 1'b1) begin fails++; $display("FAIL raw_busy6: got %b want 1", busy_vec[6]); end
    adv();
  endtask

  task automatic test_waw();
    do_reset();
    cyc(0, 1, mk(4'b0101, 6'd7, 6'd0, 6'd0), 0, 6'd0, 0);
    adv();
    cyc(0, 1, mk(4'b0101, 6'd7, 6'd0, 6'd0), 0, 6'd0, 0);
    tests++; if ({stall, issue} !== 2'b10) begin fails++; $display("FAIL waw_stall: got stall/issue %b want 10", {stall, issue}); end
    adv();
    cyc(0, 0, 32'h0, 1, 6'd7, 0);
    adv();
    cyc(0, 1, mk(4'b0101, 6'd7, 6'd0, 6'd0), 1, 6'd7, 0);
    tests++; if (issue !== 1'b1) begin fails++; $display("FAIL waw_reissue: got %b want 1", issue); end
    adv();
    cyc(0, 0, 32'h0, 0, 6'd0, 0);
    tests++; if (busy_vec[7] !== 1'b1) begin fails++; $display("FAIL set_wins: got %b want 1", busy_vec[7]); end
    adv();
  endtask

  task automatic test_redirect();
    do_reset();
    cyc(0, 1, mk(4'b0100, 6'd9, 6'd0, 6'd0), 0, 6'd0, 0);
    adv();
    cyc(0, 1, mk(4'b0100, 6'd10, 6'd9, 6'd0), 0, 6'd0, 1);
    tests++; if ({stall, issue} !== 2'b00) begin fails++; $display("FAIL redir_wins: got stall/issue %b want 00", {stall, issue}); end
    adv();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, mk(4'b0100, 6'd11, 6'd0, 6'd0), 0, 6'd0, 0);
      tests++; if (flush !== (i < 2)) begin fails++; $display("FAIL redir_flush%0d: got %b want %b", i, flush, (i < 2)); end
      tests++; if (issue !== (i == 2)) begin fails++; $display("FAIL redir_issue%0d: got %b want %b", i, issue, (i == 2)); end
      if (i == 2) begin
        tests++; if (busy_vec[10] !== 1'b0) begin fails++; $display("FAIL redir_noset: got %b want 0", busy_vec[10]); end
      end
      adv();
    end
  endtask

  task automatic test_back_to_back();
    int highs = 0;
    do_reset();
    cyc(0, 0, 32'h0, 0, 6'd0, 1);
    adv();
    cyc(0, 0, 32'h0, 0, 6'd0, 1);
    if (flush === 1'b1) highs++;
    adv();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 32'h0, 0, 6'd0, 0);
      if (flush === 1'b1) highs++;
      adv();
    end
    tests++; if (highs != 3) begin fails++; $display("FAIL b2b_flush_len: got %0d want 3", highs); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(0, 1, mk(4'b0100, 6'd1, 6'd0, 6'd0), 0, 6'd0, 0);
    adv();
    cyc(0, 1, mk(4'b0100, 6'd63, 6'd0, 6'd0), 0, 6'd0, 0);
    adv();
    cyc(0, 1, mk(4'b0111, 6'd2, 6'd1, 6'd0), 0, 6'd0, 0);
    adv();
    cyc(0, 0, 32'h0, 0, 6'd0, 1);
    adv();
    cyc(1, 0, 32'h0, 0, 6'd0, 0);
    tests++; if (busy_vec !== 64'h8000_0000_0000_0002) begin fails++; $display("FAIL mid_busy: got %h want 8000000000000002", busy_vec); end
    tests++; if ({flush, stall_cnt} !== {1'b1, 4'd1}) begin fails++; $display("FAIL mid_pre: got flush=%b cnt=%0d want 1/1", flush, stall_cnt); end
    adv();
    cyc(0, 0, 32'h0, 0, 6'd0, 0);
    tests++; if ({busy_vec, flush, stall_cnt} !== '0) begin fails++; $display("FAIL mid_reset: got busy=%h flush=%b cnt=%0d want 0", busy_vec, flush, stall_cnt); end
    adv();
  endtask

  task automatic test_saturate();
    do_reset();
    cyc(0, 1, mk(4'b0100, 6'd3, 6'd0, 6'd0), 0, 6'd0, 0);
    adv();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, mk(4'b0111, 6'd8, 6'd3, 6'd0), 0, 6'd0, 0);
      adv();
    end
    cyc(0, 1, mk(4'b0111, 6'd8, 6'd3, 6'd0), 0, 6'd0, 0);
    tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt); end
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sat_stall: got %b want 1", stall); end
    adv();
  endtask

  typedef struct {logic [3:0] op; logic [5:0] d; logic [5:0] s; logic [5:0] t; bit st;} cls_t;

  task automatic test_classes();
    cls_t tbl [16];
    tbl = '{
      '{4'b1000, 6'd0, 6'd4, 6'd0, 1}, '{4'b0000, 6'd4, 6'd4, 6'd4, 0},
      '{4'b1111, 6'd4, 6'd0, 6'd0, 1}, '{4'b1000, 6'd4, 6'd0, 6'd4, 0},
      '{4'b0011, 6'd4, 6'd0, 6'd0, 0}, '{4'b0011, 6'd0, 6'd0, 6'd4, 1},
      '{4'b1011, 6'd0, 6'd4, 6'd0, 1}, '{4'b1001, 6'd0, 6'd0, 6'd4, 0},
      '{4'b1110, 6'd4, 6'd0, 6'd0, 1}, '{4'b0110, 6'd0, 6'd4, 6'd0, 1},
      '{4'b0101, 6'd4, 6'd0, 6'd0, 1}, '{4'b0111, 6'd0, 6'd0, 6'd4, 1},
      '{4'b0100, 6'd0, 6'd0, 6'd4, 1}, '{4'b1010, 6'd0, 6'd4, 6'd0, 1},
      '{4'b1001, 6'd0, 6'd4, 6'd0, 1}, '{4'b0001, 6'd4, 6'd4, 6'd4, 0}
    };
    do_reset();
    cyc(0, 1, mk(4'b0100, 6'd4, 6'd0, 6'd0), 0, 6'd0, 0);
    adv();
    foreach (tbl[i]) begin
      cyc(0, 1, mk(tbl[i].op, tbl[i].d, tbl[i].s, tbl[i].t), 0, 6'd0, 0);
      tests++;
      if ({stall, issue} !== {tbl[i].st, !tbl[i].st}) begin
        fails++;
        $display("FAIL class_op%b_%0d: got stall/issue %b want %b", tbl[i].op, i,
                 {stall, issue}, {tbl[i].st, !tbl[i].st});
      end
      adv();
    end
  endtask

  task automatic test_random();
    logic [5:0] d, s, t;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      d = ($urandom_range(15) == 0) ? 6'd63 : 6'($urandom_range(7));
      s = 6'($urandom_range(7));
      t = 6'($urandom_range(7));
      cyc(($urandom_range(99) == 0), ($urandom_range(9) < 8), mk(4'($urandom), d, s, t),
          ($urandom_range(9) < 4), 6'($urandom_range(7)), ($urandom_range(19) == 0));
      tests++; if (stall !== exp_stall) begin fails++; $display("FAIL rnd_stall@%0d: got %b want %b", n, stall, exp_stall); end
      tests++; if (issue !== exp_issue) begin fails++; $display("FAIL rnd_issue@%0d: got %b want %b", n, issue, exp_issue); end
      tests++; if (flush !== (mflush > 0)) begin fails++; $display("FAIL rnd_flush@%0d: got %b want %b", n, flush, (mflush > 0)); end
      tests++; if (busy_vec !== mvec()) begin fails++; $display("FAIL rnd_busy@%0d: got %h want %h", n, busy_vec, mvec()); end
      tests++; if (stall_cnt !== CW'(mcnt)) begin fails++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, stall_cnt, mcnt); end
      adv();
    end
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; inst = '0; wb_rw = 1'b0; wb_rd = '0; ex_redirect = 1'b0;
    test_reset();
    test_raw();
    test_waw();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_classes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
